// File: rtl/addsub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM states, mode encodings
// and saturation limits used when ADDSUB_SAT_EN is defined.
package addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Largest positive two's-complement value of the given width (width <= 64).
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of the given width (width <= 64).
  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice. c_msb is the carry into the slice's top
// bit, needed to form signed overflow on the most significant digit.
module addsub_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout_d,
  output logic             c_msb
);

  // Slice sum; the carry into the top bit is recovered from its sum bit.
  always_comb begin
    {cout_d, s_d} = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, cin};
    c_msb         = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ s_d[DIGIT-1];
  end

endmodule

// File: rtl/serial_sub_adder.sv
// Multi-cycle signed adder/subtractor: one DIGIT-bit slice iterated WIDTH/DIGIT
// times, valid/ready on both sides. Define ADDSUB_SAT_EN to saturate the sum
// on signed overflow (cout/of stay raw).
module serial_sub_adder
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e state_q, state_d;

  // Operands shift right one digit per CALC cycle; b_q holds b already inverted for subtract.
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, of_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout, dig_cmsb;
  logic             last_digit, of_raw;
  logic [WIDTH-1:0] sum_raw, sum_fin;

  addsub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a_d   (a_q[DIGIT-1:0]),
    .b_d   (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s_d   (dig_sum),
    .cout_d(dig_cout),
    .c_msb (dig_cmsb)
  );

  assign last_digit = (cnt_q == CNT_W'(N - 1));
  // Result digits enter from the top so the full word is aligned after N shifts.
  assign sum_raw    = {dig_sum, sum_q[WIDTH-1:DIGIT]};
  assign of_raw     = dig_cmsb ^ dig_cout;

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SatMin = WIDTH'(sat_min(WIDTH));
  // On overflow the raw sign is inverted: raw negative means positive overflow.
  assign sum_fin = of_raw ? (sum_raw[WIDTH-1] ? SatMax : SatMin) : sum_raw;
`else
  assign sum_fin = sum_raw;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StCalc;
      end
      StCalc: begin
        if (last_digit) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, digit iteration and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      of_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{mode}};
            carry_q <= mode;
            cnt_q   <= '0;
          end
        end
        StCalc: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dig_cout;
          if (last_digit) begin
            sum_q  <= sum_fin;
            cout_q <= dig_cout;
            of_q   <= of_raw;
            cnt_q  <= '0;
          end else begin
            sum_q <= sum_raw;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign of   = of_q;

endmodule
